// File: rtl/div_iterative_if.sv
// div_iterative_if: operand/result bundle between the multicycle control unit
// and the iterative signed divider. The control unit is the master; the
// divider is the slave.
interface div_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ready;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, a, b,
    input  hi, lo, ready, div_zero, busy
  );

  modport slave (
    input  start, a, b,
    output hi, lo, ready, div_zero, busy
  );
endinterface

// File: rtl/div_iterative.sv
// div_iterative: sequential signed divider for the DIV instruction.
// Restoring algorithm on operand magnitudes, one quotient bit per cycle,
// followed by a sign-fix cycle that writes quotient to lo and remainder to hi.
// The quotient truncates toward zero and the remainder follows the dividend.
// Optional feature macro: DIV_ZERO_TRAP_EN -- when defined, a zero divisor
// skips the iteration and raises a one-cycle div_zero pulse with ready,
// leaving hi/lo untouched. When undefined, div_zero is tied low and a zero
// divisor runs the normal path.
module div_iterative #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  div_iterative_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
`ifdef DIV_ZERO_TRAP_EN
  localparam logic [1:0] ZERO = 2'd3;
`endif

  logic [1:0]       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             sign_q;
  logic             sign_r;
  logic             ready_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
`ifdef DIV_ZERO_TRAP_EN
  logic             dz_q;
`endif

  // Operand magnitudes and the trial subtraction of one restoring step;
  // two's complement wrap makes the magnitude of the most negative value
  // come out as the correct unsigned number.
  always_comb begin
    a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
  end

  // Control FSM plus the shared remainder/quotient datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      ready_q <= 1'b0;
      count   <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo     <= a_mag;
            divisor <= b_mag;
            sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_r  <= bus.a[WIDTH-1];
            rem     <= '0;
            count   <= CW'(WIDTH);
`ifdef DIV_ZERO_TRAP_EN
            state   <= (bus.b == '0) ? ZERO : RUN;
`else
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          if (trial[WIDTH+1]) begin
            rem <= shifted[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          lo_q    <= sign_q ? -quo : quo;
          hi_q    <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          ready_q <= 1'b1;
          state   <= IDLE;
        end
`ifdef DIV_ZERO_TRAP_EN
        ZERO: begin
          ready_q <= 1'b1;
          dz_q    <= 1'b1;
          state   <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.ready = ready_q;
  assign bus.busy  = (state == RUN) || (state == FIX);
`ifdef DIV_ZERO_TRAP_EN
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_iterative.sv
// tb_div_iterative: self-checking bench for div_iterative. Directed vectors
// from a table, hand-written busy/abort/back-to-back sequences, and random
// operands compared with a plain-arithmetic reference model. Expectations
// for a zero divisor follow DIV_ZERO_TRAP_EN the same way the design does.
module tb_div_iterative;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs [6];

  div_iterative_if #(.WIDTH(WIDTH)) bus ();

  div_iterative #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: signed 64-bit arithmetic gives truncating quotient and
  // dividend-signed remainder; the low 32 bits give the wrapped results.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic dz, output int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
`ifdef DIV_ZERO_TRAP_EN
      lo  = model_lo;
      hi  = model_hi;
      dz  = 1'b1;
      lat = 1;
`else
      lo  = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
      hi  = a;
      dz  = 1'b0;
      lat = 33;
`endif
    end else begin
      lo  = 32'(sa / sb);
      hi  = 32'(sa % sb);
      dz  = 1'b0;
      lat = 33;
    end
  endfunction

  // Called #1 after a rising edge; returns #1 after the start edge E0 with
  // the operands already scrambled so any late sampling is visible.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = b ^ 32'h5A5A_0001;
  endtask

  // Counts edges after E0 until ready is seen; optionally pokes a second
  // start while the divider is busy. Returns -1 when the budget runs out.
  task automatic wait_ready(input int poke_at, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == poke_at) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else if (k == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a,
                               input logic [31:0] b, input int poke_at);
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
    int          exp_lat;
    int          lat;
    ref_model(a, b, exp_lo, exp_hi, exp_dz, exp_lat);
    applyStimulus(a, b);
    checkOutput({name, ".busy"}, 32'(bus.busy), exp_dz ? 32'd0 : 32'd1);
    wait_ready(poke_at, lat);
    checkOutput({name, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, ".lo"}, bus.lo, exp_lo);
    checkOutput({name, ".hi"}, bus.hi, exp_hi);
    checkOutput({name, ".div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
    @(posedge clk);
    #1;
    checkOutput({name, ".ready_drop"}, 32'(bus.ready), 32'd0);
    checkOutput({name, ".dz_drop"}, 32'(bus.div_zero), 32'd0);
    checkOutput({name, ".busy_after"}, 32'(bus.busy), 32'd0);
    model_lo = exp_lo;
    model_hi = exp_hi;
  endtask

  initial begin
    int          pulses [$];
    int          quiet_ready;
    int          sel;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        prev_ready;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{32'd7,          32'd100,        32'd0,          32'd7};
    vecs[5] = '{32'd9,          32'd2,          32'd4,          32'd1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.hi", bus.hi, 32'd0);
    checkOutput("reset.lo", bus.lo, 32'd0);
    checkOutput("reset.ready", 32'(bus.ready), 32'd0);
    checkOutput("reset.div_zero", 32'(bus.div_zero), 32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table; each entry also checked against the model's view.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] m_lo;
      logic [31:0] m_hi;
      logic        m_dz;
      int          m_lat;
      ref_model(vecs[i].a, vecs[i].b, m_lo, m_hi, m_dz, m_lat);
      checkOutput($sformatf("table%0d.model_lo", i), m_lo, vecs[i].exp_lo);
      checkOutput($sformatf("table%0d.model_hi", i), m_hi, vecs[i].exp_hi);
      run_and_check($sformatf("table%0d", i), vecs[i].a, vecs[i].b, 0);
      checkOutput($sformatf("table%0d.lo_const", i), bus.lo, vecs[i].exp_lo);
      checkOutput($sformatf("table%0d.hi_const", i), bus.hi, vecs[i].exp_hi);
    end

    // Divide by zero right after 9/2 left lo=4, hi=1.
    run_and_check("div0_9", 32'd9, 32'd0, 0);
`ifdef DIV_ZERO_TRAP_EN
    checkOutput("div0_9.lo_kept", bus.lo, 32'd4);
    checkOutput("div0_9.hi_kept", bus.hi, 32'd1);
`else
    checkOutput("div0_9.lo_raw", bus.lo, 32'hFFFF_FFFF);
    checkOutput("div0_9.hi_raw", bus.hi, 32'd9);
    run_and_check("div0_5", 32'd5, 32'd0, 0);
    run_and_check("div0_m5", 32'hFFFF_FFFB, 32'd0, 0);
    checkOutput("div0_m5.lo", bus.lo, 32'd1);
    checkOutput("div0_m5.hi", bus.hi, 32'hFFFF_FFFB);
`endif

    // Start while busy is ignored.
    run_and_check("busy_ignore", 32'd100, 32'd7, 5);
    checkOutput("busy_ignore.lo", bus.lo, 32'd14);
    checkOutput("busy_ignore.hi", bus.hi, 32'd2);

    // Reset mid-operation aborts and clears everything.
    applyStimulus(32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort.hi", bus.hi, 32'd0);
    checkOutput("abort.lo", bus.lo, 32'd0);
    checkOutput("abort.ready", 32'(bus.ready), 32'd0);
    checkOutput("abort.div_zero", 32'(bus.div_zero), 32'd0);
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    quiet_ready = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) quiet_ready++;
    end
    checkOutput("abort.no_ready", 32'(quiet_ready), 32'd0);
    model_lo = '0;
    model_hi = '0;

    // Back-to-back with start held high: one result every 34 cycles.
    bus.a      = 32'd50;
    bus.b      = 32'd5;
    bus.start  = 1'b1;
    prev_ready = 1'b0;
    for (int k = 0; k <= 140 && pulses.size() < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        pulses.push_back(k);
        checkOutput("b2b.lo", bus.lo, 32'd10);
        checkOutput("b2b.hi", bus.hi, 32'd0);
        checkOutput("b2b.single_cycle", 32'(prev_ready), 32'd0);
      end
      prev_ready = bus.ready;
    end
    bus.start = 1'b0;
    checkOutput("b2b.pulses", 32'(pulses.size()), 32'd3);
    for (int i = 0; i < pulses.size(); i++) begin
      checkOutput($sformatf("b2b.edge%0d", i), 32'(pulses[i]), 32'(33 + 34 * i));
    end
    @(posedge clk);
    #1;
    checkOutput("b2b.ready_drop", 32'(bus.ready), 32'd0);
    model_lo = 32'd10;
    model_hi = 32'd0;
    @(posedge clk);
    #1;

    // Random operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: begin
          rb = $urandom_range(1, 15);
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: rb = $urandom;
      endcase
      run_and_check($sformatf("rand%0d", i), ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
